// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with register-array storage, any depth >= 2.
// It supports a standard read mode and a first-word-fall-through (FWFT) read mode.
// It also provides a level count, programmable almost flags, sticky
// overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clk          clock, all logic on posedge
//   rstn         asynchronous active-low reset
//   flush        synchronous clear of contents and error flags (highest priority)
//   write        write request; writeData is the word to store
//   read         read request (FWFT: acknowledge of the word on readData)
//   readData     registered read data
//   empty/full   level == 0 / level == depth
//   almostEmpty  level <= almostEmptyThr
//   almostFull   level >= almostFullThr
//   level        number of stored words
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sync_fifo #(
    parameter int width          = 8,
    parameter int depth          = 16,
    parameter int fwft           = 0,
    parameter int almostFullThr  = depth - 2,
    parameter int almostEmptyThr = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       write,
    input  logic [width-1:0]           writeData,
    input  logic                       read,
    output logic [width-1:0]           readData,
    output logic                       empty,
    output logic                       full,
    output logic                       almostEmpty,
    output logic                       almostFull,
    output logic [$clog2(depth+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LW = $clog2(depth + 1);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    generate
        if (depth < 2) begin : gBadDepth
            $error("sync_fifo: depth must be >= 2");
        end
        if (almostFullThr < 1 || almostFullThr > depth) begin : gBadAfThr
            $error("sync_fifo: almostFullThr must be in 1..depth");
        end
        if (almostEmptyThr < 0 || almostEmptyThr > depth - 1) begin : gBadAeThr
            $error("sync_fifo: almostEmptyThr must be in 0..depth-1");
        end
    endgenerate

    // Pointer increment with explicit wrap, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(depth - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1'b1);
        end
        return r;
    endfunction

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;

    logic             wrAcc;
    logic             rdAcc;
    logic [PW-1:0]    wrPtrNext;
    logic [PW-1:0]    rdPtrNext;
    logic [LW-1:0]    levelNext;
    logic [width-1:0] readDataNext;
    logic             overflowNext;
    logic             underflowNext;

    // Accept/reject decisions and next-state values for pointers, level, data and error flags.
    always_comb begin
        wrAcc         = 1'b0;
        rdAcc         = 1'b0;
        wrPtrNext     = wrPtr;
        rdPtrNext     = rdPtr;
        levelNext     = level;
        readDataNext  = readData;
        overflowNext  = overflow;
        underflowNext = underflow;

        if (flush) begin
            wrPtrNext     = '0;
            rdPtrNext     = '0;
            levelNext     = '0;
            overflowNext  = 1'b0;
            underflowNext = 1'b0;
        end else begin
            // full/empty are registered copies of the current level, so they gate acceptance directly.
            wrAcc = write && !full;
            rdAcc = read && !empty;

            if (wrAcc) begin
                wrPtrNext = ptrInc(wrPtr);
            end else begin
                wrPtrNext = wrPtr;
            end

            if (rdAcc) begin
                rdPtrNext = ptrInc(rdPtr);
            end else begin
                rdPtrNext = rdPtr;
            end

            case ({wrAcc, rdAcc})
                2'b10:   levelNext = level + LW'(1'b1);
                2'b01:   levelNext = level - LW'(1'b1);
                default: levelNext = level;
            endcase

            if (write && full) begin
                overflowNext = 1'b1;
            end else begin
                overflowNext = overflow;
            end

            if (read && empty) begin
                underflowNext = 1'b1;
            end else begin
                underflowNext = underflow;
            end

            if (fwft != 0) begin
                // The next head may be the word written this very cycle (empty FIFO,
                // or a read draining the last stored word while a new one arrives).
                if (levelNext != '0) begin
                    if (wrAcc && (wrPtr == rdPtrNext)) begin
                        readDataNext = writeData;
                    end else begin
                        readDataNext = mem[rdPtrNext];
                    end
                end else begin
                    readDataNext = readData;
                end
            end else begin
                if (rdAcc) begin
                    readDataNext = mem[rdPtr];
                end else begin
                    readDataNext = readData;
                end
            end
        end
    end

    // Storage array; it is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem[wrPtr] <= writeData;
        end
    end

    // Control state and registered outputs; the flags are derived from the next level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            level       <= '0;
            readData    <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almostEmpty <= 1'b1;
            almostFull  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wrPtr       <= wrPtrNext;
            rdPtr       <= rdPtrNext;
            level       <= levelNext;
            readData    <= readDataNext;
            empty       <= (levelNext == '0);
            full        <= (levelNext == LW'(depth));
            almostEmpty <= (levelNext <= LW'(almostEmptyThr));
            almostFull  <= (levelNext >= LW'(almostFullThr));
            overflow    <= overflowNext;
            underflow   <= underflowNext;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo. Three instances share one stimulus stream:
//   u0: depth 4, standard read;  u1: depth 4, FWFT;  u2: depth 5, standard read.
// Each scenario task resets first, then checks only the instance it targets.
// Status vectors are packed as {empty, full, almostEmpty, almostFull, overflow, underflow}.
module tb_sync_fifo;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       write;
    logic [7:0] writeData;
    logic       read;

    logic [7:0] rd0, rd1, rd2;
    logic [2:0] lvl0, lvl1, lvl2;
    logic e0, f0, ae0, af0, ov0, un0;
    logic e1, f1, ae1, af1, ov1, un1;
    logic e2, f2, ae2, af2, ov2, un2;
    logic [5:0] st0, st1, st2;

    int vectors;
    int miscompares;

    assign st0 = {e0, f0, ae0, af0, ov0, un0};
    assign st1 = {e1, f1, ae1, af1, ov1, un1};
    assign st2 = {e2, f2, ae2, af2, ov2, un2};

    sync_fifo #(.width(8), .depth(4), .fwft(0), .almostFullThr(3), .almostEmptyThr(1)) u0 (
        .clk(clk), .rstn(rstn), .flush(flush), .write(write), .writeData(writeData),
        .read(read), .readData(rd0), .empty(e0), .full(f0), .almostEmpty(ae0),
        .almostFull(af0), .level(lvl0), .overflow(ov0), .underflow(un0));

    sync_fifo #(.width(8), .depth(4), .fwft(1), .almostFullThr(3), .almostEmptyThr(1)) u1 (
        .clk(clk), .rstn(rstn), .flush(flush), .write(write), .writeData(writeData),
        .read(read), .readData(rd1), .empty(e1), .full(f1), .almostEmpty(ae1),
        .almostFull(af1), .level(lvl1), .overflow(ov1), .underflow(un1));

    sync_fifo #(.width(8), .depth(5), .fwft(0), .almostFullThr(3), .almostEmptyThr(1)) u2 (
        .clk(clk), .rstn(rstn), .flush(flush), .write(write), .writeData(writeData),
        .read(read), .readData(rd2), .empty(e2), .full(f2), .almostEmpty(ae2),
        .almostFull(af2), .level(lvl2), .overflow(ov2), .underflow(un2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock with the given requests, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic fl);
        write     = w;
        writeData = d;
        read      = r;
        flush     = fl;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic applyReset();
        write = 1'b0; read = 1'b0; flush = 1'b0; writeData = 8'h00;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (st0 !== 6'b101000) begin miscompares++; $display("FAIL reset_status got %b expected %b", st0, 6'b101000); end
        vectors++;
        if (lvl0 !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d expected 0", lvl0); end
        vectors++;
        if (rd0 !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h expected 00", rd0); end
        vectors++;
        if (st1 !== 6'b101000) begin miscompares++; $display("FAIL reset_status_fwft got %b expected %b", st1, 6'b101000); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] wd   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [5:0] wst  [5] = '{6'b001000, 6'b000000, 6'b000100, 6'b010100, 6'b010110};
        logic [2:0] wlv  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [7:0] rdd  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [5:0] rst_ [4] = '{6'b000110, 6'b000010, 6'b001010, 6'b101010};
        logic [2:0] rlv  [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        applyReset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, wd[i], 1'b0, 1'b0);
            vectors++;
            if (st0 !== wst[i]) begin miscompares++; $display("FAIL fill_status[%0d] got %b expected %b", i, st0, wst[i]); end
            vectors++;
            if (lvl0 !== wlv[i]) begin miscompares++; $display("FAIL fill_level[%0d] got %0d expected %0d", i, lvl0, wlv[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (rd0 !== rdd[i]) begin miscompares++; $display("FAIL drain_data[%0d] got %h expected %h", i, rd0, rdd[i]); end
            vectors++;
            if (st0 !== rst_[i]) begin miscompares++; $display("FAIL drain_status[%0d] got %b expected %b", i, st0, rst_[i]); end
            vectors++;
            if (lvl0 !== rlv[i]) begin miscompares++; $display("FAIL drain_level[%0d] got %0d expected %0d", i, lvl0, rlv[i]); end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (rd0 !== 8'h44) begin miscompares++; $display("FAIL drain_hold got %h expected 44", rd0); end
    endtask

    task automatic test_fwft();
        applyReset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        vectors++;
        if (st1 !== 6'b001000) begin miscompares++; $display("FAIL fwft_status got %b expected %b", st1, 6'b001000); end
        vectors++;
        if (rd1 !== 8'hA5) begin miscompares++; $display("FAIL fwft_first got %h expected a5", rd1); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (st1 !== 6'b101000) begin miscompares++; $display("FAIL fwft_empty got %b expected %b", st1, 6'b101000); end
        vectors++;
        if (rd1 !== 8'hA5) begin miscompares++; $display("FAIL fwft_hold got %h expected a5", rd1); end
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        vectors++;
        if (rd1 !== 8'h01 || lvl1 !== 3'd2) begin miscompares++; $display("FAIL fwft_head got %h/%0d expected 01/2", rd1, lvl1); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (rd1 !== 8'h02) begin miscompares++; $display("FAIL fwft_next got %h expected 02", rd1); end
        // Read and write together at level 1: the new word becomes head immediately.
        step(1'b1, 8'h03, 1'b1, 1'b0);
        vectors++;
        if (rd1 !== 8'h03 || lvl1 !== 3'd1) begin miscompares++; $display("FAIL fwft_rw got %h/%0d expected 03/1", rd1, lvl1); end
    endtask

    task automatic test_wrap();
        applyReset();
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 8'h12 + 8'(k), 1'b1, 1'b0);
            vectors++;
            if (rd2 !== 8'h10 + 8'(k)) begin miscompares++; $display("FAIL wrap_data[%0d] got %h expected %h", k, rd2, 8'h10 + 8'(k)); end
            vectors++;
            if (lvl2 !== 3'd2 || st2 !== 6'b000000) begin miscompares++; $display("FAIL wrap_state[%0d] got %0d/%b expected 2/000000", k, lvl2, st2); end
        end
    endtask

    task automatic test_underflow_flush();
        applyReset();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (st0 !== 6'b101001) begin miscompares++; $display("FAIL underflow_status got %b expected %b", st0, 6'b101001); end
        vectors++;
        if (rd0 !== 8'h3C) begin miscompares++; $display("FAIL underflow_data got %h expected 3c", rd0); end
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        vectors++;
        if (st0 !== 6'b101000 || lvl0 !== 3'd0) begin miscompares++; $display("FAIL flush_state got %b/%0d expected 101000/0", st0, lvl0); end
        vectors++;
        if (rd0 !== 8'h3C) begin miscompares++; $display("FAIL flush_data got %h expected 3c", rd0); end
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (rd0 !== 8'hAB || lvl0 !== 3'd0) begin miscompares++; $display("FAIL flush_after got %h/%0d expected ab/0", rd0, lvl0); end
    endtask

    task automatic test_reset_midstream();
        applyReset();
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b1, 1'b0);
        vectors++;
        if (lvl0 !== 3'd3 || rd0 !== 8'h01 || st0 !== 6'b000100) begin
            miscompares++; $display("FAIL mid_pre got %0d/%h/%b expected 3/01/000100", lvl0, rd0, st0);
        end
        write = 1'b1; writeData = 8'hEE; read = 1'b1;
        rstn = 1'b0;
        #1;
        vectors++;
        if (lvl0 !== 3'd0 || rd0 !== 8'h00 || st0 !== 6'b101000) begin
            miscompares++; $display("FAIL mid_reset got %0d/%h/%b expected 0/00/101000", lvl0, rd0, st0);
        end
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0;
        rstn = 1'b1;
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (rd0 !== 8'hC1) begin miscompares++; $display("FAIL mid_first got %h expected c1", rd0); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (rd0 !== 8'hC2 || st0 !== 6'b101000) begin miscompares++; $display("FAIL mid_second got %h/%b expected c2/101000", rd0, st0); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; writeData = 8'h00;
        #2;
        test_reset();
        test_fill_overflow();
        test_fwft();
        test_wrap();
        test_underflow_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
